multi_cycle_cpu: RTL and testbench

MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

---
 rtl/multi_cycle_cpu.sv | 203 ++++++++++++++++++++
 tb/tb_multi_cycle_cpu.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT over a single
// request/ready memory port. Supports add/sub/and/or/slt, addi, load, store, beq.
module multi_cycle_cpu #(
    parameter int            XLEN     = 64,
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ready_i,
    output logic [AW-1:0]   pc_o,
    output logic            retire_o,
    output logic            halt_o
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [1:0] {C_ALU, C_LOAD, C_STORE, C_BEQ} cls_t;
    typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_SLT} alu_t;

    localparam logic [XLEN-1:0] ZERO_X  = {XLEN{1'b0}};
    localparam logic [AW-1:0]   PC_STEP = AW'(32'd4);
    localparam logic [2:0]      LS_F3   = (XLEN == 64) ? 3'b011 : 3'b010;

    state_t          r_state;
    cls_t            r_cls;
    alu_t            r_alu;
    logic            r_use_imm;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_oldpc;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_res;
    logic [XLEN-1:0] r_mdr;
    logic [XLEN-1:0] r_rf [32];

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_legal;
    cls_t            w_cls;
    alu_t            w_alu;
    logic            w_use_imm;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_opb;
    logic [XLEN-1:0] w_alu_res;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_funct7 = r_ir[31:25];

    // Instruction decode: legality, operation class and sign-extended immediate.
    always_comb begin
        w_legal   = 1'b0;
        w_cls     = C_ALU;
        w_alu     = A_ADD;
        w_use_imm = 1'b1;
        w_imm     = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
        case (w_opcode)
            7'b0110011: begin
                w_use_imm = 1'b0;
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000:  begin w_legal = 1'b1; w_alu = A_ADD; end
                        3'b111:  begin w_legal = 1'b1; w_alu = A_AND; end
                        3'b110:  begin w_legal = 1'b1; w_alu = A_OR;  end
                        3'b010:  begin w_legal = 1'b1; w_alu = A_SLT; end
                        default: w_legal = 1'b0;
                    endcase
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_legal = 1'b1;
                    w_alu   = A_SUB;
                end else begin
                    w_legal = 1'b0;
                end
            end
            7'b0010011: w_legal = (w_funct3 == 3'b000);
            7'b0000011: begin
                w_legal = (w_funct3 == LS_F3);
                w_cls   = C_LOAD;
            end
            7'b0100011: begin
                w_legal = (w_funct3 == LS_F3);
                w_cls   = C_STORE;
                w_imm   = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            end
            7'b1100011: begin
                w_legal = (w_funct3 == 3'b000);
                w_cls   = C_BEQ;
                w_imm   = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            end
            default: w_legal = 1'b0;
        endcase
    end

    // ALU; load/store addresses reuse the add path with the immediate operand.
    always_comb begin
        w_opb = r_use_imm ? r_imm : r_b;
        case (r_alu)
            A_ADD:   w_alu_res = r_a + w_opb;
            A_SUB:   w_alu_res = r_a - w_opb;
            A_AND:   w_alu_res = r_a & w_opb;
            A_OR:    w_alu_res = r_a | w_opb;
            A_SLT:   w_alu_res = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_opb))};
            default: w_alu_res = r_a + w_opb;
        endcase
    end

    // Control FSM with the architectural state and register file.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state   <= S_FETCH;
            r_cls     <= C_ALU;
            r_alu     <= A_ADD;
            r_use_imm <= 1'b0;
            r_pc      <= RESET_PC;
            r_oldpc   <= RESET_PC;
            r_addr    <= {AW{1'b0}};
            r_ir      <= 32'd0;
            r_a       <= ZERO_X;
            r_b       <= ZERO_X;
            r_imm     <= ZERO_X;
            r_res     <= ZERO_X;
            r_mdr     <= ZERO_X;
            for (int i = 0; i < 32; i++) r_rf[i] <= ZERO_X;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready_i) begin
                        r_ir    <= mem_rdata_i[31:0];
                        r_oldpc <= r_pc;
                        r_pc    <= r_pc + PC_STEP;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a       <= (w_rs1 == 5'd0) ? ZERO_X : r_rf[w_rs1];
                    r_b       <= (w_rs2 == 5'd0) ? ZERO_X : r_rf[w_rs2];
                    r_imm     <= w_imm;
                    r_cls     <= w_cls;
                    r_alu     <= w_alu;
                    r_use_imm <= w_use_imm;
                    r_state   <= w_legal ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    case (r_cls)
                        C_BEQ: begin
                            if (r_a == r_b) r_pc <= r_oldpc + r_imm[AW-1:0];
                            r_state <= S_FETCH;
                        end
                        C_LOAD, C_STORE: begin
                            r_addr  <= w_alu_res[AW-1:0];
                            r_state <= S_MEM;
                        end
                        default: begin
                            r_res   <= w_alu_res;
                            r_state <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready_i) begin
                        if (r_cls == C_LOAD) begin
                            r_mdr   <= mem_rdata_i;
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (w_rd != 5'd0) r_rf[w_rd] <= (r_cls == C_LOAD) ? r_mdr : r_res;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Outputs are selects of registered state; the request is also gated by reset.
    assign mem_req_o   = nrst_i && (r_state == S_FETCH || r_state == S_MEM);
    assign mem_we_o    = (r_state == S_MEM) && (r_cls == C_STORE);
    assign mem_addr_o  = (r_state == S_FETCH) ? r_pc : r_addr;
    assign mem_wdata_o = r_b;
    assign pc_o        = (r_state == S_FETCH) ? r_pc : r_oldpc;
    assign halt_o      = (r_state == S_HALT);
    assign retire_o    = (r_state == S_WB) ||
                         (r_state == S_EXEC && r_cls == C_BEQ) ||
                         (r_state == S_MEM && r_cls == C_STORE && mem_ready_i);
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Scoreboard bench for multi_cycle_cpu: directed programs push expected memory
// transactions, retires and halts; a monitor/responder pops and compares them.
module tb_multi_cycle_cpu;
    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BR = 7'b1100011;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        mem_req, mem_we, mem_ready = 1'b0, retire, halt;
    logic [31:0] mem_addr, pc;
    logic [63:0] mem_wdata, mem_rdata = 64'd0;

    logic        nrst32 = 1'b0, req32, we32, ready32 = 1'b1, retire32, halt32;
    logic [31:0] addr32, wdata32, rdata32 = 32'd0, pc32;

    always #5 clk = ~clk;

    multi_cycle_cpu #(.XLEN(64), .AW(32), .RESET_PC(32'h0)) u_dut (
        .clk_i(clk), .nrst_i(nrst), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready), .pc_o(pc), .retire_o(retire), .halt_o(halt));

    multi_cycle_cpu #(.XLEN(32), .AW(32), .RESET_PC(32'h0)) u_dut32 (
        .clk_i(clk), .nrst_i(nrst32), .mem_req_o(req32), .mem_we_o(we32),
        .mem_addr_o(addr32), .mem_wdata_o(wdata32), .mem_rdata_i(rdata32),
        .mem_ready_i(ready32), .pc_o(pc32), .retire_o(retire32), .halt_o(halt32));

    typedef enum logic [1:0] {EV_READ, EV_STORE, EV_RETIRE, EV_HALT} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] addr;
        logic [63:0] data;
        bit          chk_data;
    } ev_t;

    ev_t         exp_q[$];
    bit [7:0]    mem [int unsigned];
    int          n_cmp = 0, n_err = 0;
    int          wait_cfg = 0;
    int          cyc = 0;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], ST};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], BR};
    endfunction

    function automatic logic [63:0] rd64(input logic [31:0] a);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 8; i++)
            if (mem.exists(a + i)) v[i*8 +: 8] = mem[a + i];
        return v;
    endfunction

    task automatic put32(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + i] = w[i*8 +: 8];
    endtask

    task automatic push(input ev_kind_t k, input logic [31:0] a, input logic [63:0] d, input bit cd);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.chk_data = cd;
        exp_q.push_back(e);
    endtask
    task automatic p_rd(input logic [31:0] a);                      push(EV_READ, a, 64'd0, 1'b0);   endtask
    task automatic p_st(input logic [31:0] a, input logic [63:0] d); push(EV_STORE, a, d, 1'b1);      endtask
    task automatic p_ret(input logic [31:0] a, input int c);        push(EV_RETIRE, a, 64'(c), c >= 0); endtask
    task automatic p_halt(input logic [31:0] a);                    push(EV_HALT, a, 64'd0, 1'b0);   endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    task automatic check_ev(input ev_kind_t k, input logic [31:0] a, input logic [63:0] d);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required none", k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.addr !== a || (e.chk_data && e.data !== d)) begin
                n_err++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h%s",
                         k, a, d, e.kind, e.addr, e.data, e.chk_data ? "" : " (data unchecked)");
            end
        end
    endtask

    // Memory responder and scoreboard monitor, both on the falling edge.
    initial begin : monitor
        int          waitcnt = 0;
        logic        prev_halt = 1'b0;
        logic [31:0] lat_addr = 32'd0;
        logic        lat_we = 1'b0;
        logic [63:0] lat_wdata = 64'd0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                mem_ready = 1'b0; waitcnt = 0; cyc = 0; prev_halt = 1'b0;
            end else begin
                cyc++;
                if (mem_req) begin
                    if (waitcnt == 0) begin
                        lat_addr = mem_addr; lat_we = mem_we; lat_wdata = mem_wdata;
                    end else begin
                        n_cmp++;
                        if (mem_addr !== lat_addr || mem_we !== lat_we || (lat_we && mem_wdata !== lat_wdata)) begin
                            n_err++;
                            $display("FAIL mem_stable: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                                     mem_addr, mem_we, mem_wdata, lat_addr, lat_we, lat_wdata);
                        end
                    end
                    if (waitcnt >= wait_cfg) begin
                        mem_ready = 1'b1;
                        waitcnt   = 0;
                        if (mem_we) for (int i = 0; i < 8; i++) mem[mem_addr + i] = mem_wdata[i*8 +: 8];
                        else mem_rdata = rd64(mem_addr);
                    end else begin
                        mem_ready = 1'b0;
                        waitcnt++;
                    end
                end else begin
                    mem_ready = 1'b0;
                    waitcnt   = 0;
                end
                #1;
                if (mem_req && mem_ready) check_ev(mem_we ? EV_STORE : EV_READ, mem_addr, mem_wdata);
                if (retire) check_ev(EV_RETIRE, pc, 64'(cyc));
                if (halt && !prev_halt) check_ev(EV_HALT, pc, 64'd0);
                prev_halt = halt;
            end
        end
    end

    task automatic enter_reset();
        @(negedge clk); #2;
        nrst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        nrst = 1'b1;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
        repeat (6) @(posedge clk);
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : main
        int found;
        int cnt;
        // Reset state
        #12;
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_retire", {63'd0, retire}, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_pc", {32'd0, pc}, 64'd0);
        chk("rst_req32", {63'd0, req32}, 64'd0);

        // Test A: ALU ops, not-taken beq, x0 behaviour, zero-wait latencies
        put32(32'h00, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI));
        put32(32'h04, enc_i(12'd7, 5'd0, 3'b000, 5'd2, OPI));
        put32(32'h08, enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3));
        put32(32'h0C, enc_s(12'h100, 5'd3, 5'd0, 3'b011));
        put32(32'h10, enc_b(13'd8, 5'd2, 5'd1));
        put32(32'h14, enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd5));
        put32(32'h18, enc_r(7'b0000000, 5'd0, 5'd5, 3'b010, 5'd6));
        put32(32'h1C, enc_i(12'd9, 5'd0, 3'b000, 5'd0, OPI));
        put32(32'h20, enc_s(12'h108, 5'd5, 5'd0, 3'b011));
        put32(32'h24, enc_s(12'h110, 5'd6, 5'd0, 3'b011));
        put32(32'h28, enc_s(12'h118, 5'd0, 5'd0, 3'b011));
        put32(32'h2C, enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd7));
        put32(32'h30, enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd8));
        put32(32'h34, enc_s(12'h120, 5'd7, 5'd0, 3'b011));
        put32(32'h38, enc_s(12'h128, 5'd8, 5'd0, 3'b011));
        put32(32'h3C, enc_r(7'b0000000, 5'd5, 5'd0, 3'b010, 5'd9));
        put32(32'h40, enc_s(12'h130, 5'd9, 5'd0, 3'b011));
        put32(32'h44, 32'h0000_007F);
        p_rd(32'h00); p_ret(32'h00, 4);
        p_rd(32'h04); p_ret(32'h04, 8);
        p_rd(32'h08); p_ret(32'h08, 12);
        p_rd(32'h0C); p_st(32'h100, 64'd12); p_ret(32'h0C, 16);
        p_rd(32'h10); p_ret(32'h10, 19);
        p_rd(32'h14); p_ret(32'h14, 23);
        p_rd(32'h18); p_ret(32'h18, 27);
        p_rd(32'h1C); p_ret(32'h1C, 31);
        p_rd(32'h20); p_st(32'h108, 64'hFFFF_FFFF_FFFF_FFFB); p_ret(32'h20, 35);
        p_rd(32'h24); p_st(32'h110, 64'd1); p_ret(32'h24, 39);
        p_rd(32'h28); p_st(32'h118, 64'd0); p_ret(32'h28, 43);
        p_rd(32'h2C); p_ret(32'h2C, 47);
        p_rd(32'h30); p_ret(32'h30, 51);
        p_rd(32'h34); p_st(32'h120, 64'd5); p_ret(32'h34, 55);
        p_rd(32'h38); p_st(32'h128, 64'd7); p_ret(32'h38, 59);
        p_rd(32'h3C); p_ret(32'h3C, 63);
        p_rd(32'h40); p_st(32'h130, 64'd0); p_ret(32'h40, 67);
        p_rd(32'h44); p_halt(32'h44);
        release_reset();
        drain("drain_alu", 500);
        chk("halt_after_alu", {63'd0, halt}, 64'd1);

        // Test B: store then load with a 3-cycle ready wait
        enter_reset();
        mem.delete();
        wait_cfg = 3;
        put32(32'h00, enc_i(12'd12, 5'd0, 3'b000, 5'd3, OPI));
        put32(32'h04, enc_b(13'd16, 5'd0, 5'd0));
        put32(32'h14, enc_s(12'd8, 5'd3, 5'd0, 3'b011));
        put32(32'h18, enc_i(12'd8, 5'd0, 3'b011, 5'd4, LD));
        put32(32'h1C, enc_s(12'd64, 5'd4, 5'd0, 3'b011));
        put32(32'h20, 32'h0000_007F);
        p_rd(32'h00); p_ret(32'h00, -1);
        p_rd(32'h04); p_ret(32'h04, -1);
        p_rd(32'h14); p_st(32'h08, 64'd12); p_ret(32'h14, -1);
        p_rd(32'h18); p_rd(32'h08); p_ret(32'h18, -1);
        p_rd(32'h1C); p_st(32'h40, 64'd12); p_ret(32'h1C, -1);
        p_rd(32'h20); p_halt(32'h20);
        release_reset();
        drain("drain_mem", 1000);

        // Test C: reset pulsed while a store waits in MEM
        enter_reset();
        mem.delete();
        wait_cfg = 50;
        put32(32'h00, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI));
        put32(32'h04, enc_s(12'd8, 5'd1, 5'd0, 3'b011));
        p_rd(32'h00); p_ret(32'h00, -1); p_rd(32'h04);
        release_reset();
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk); #2;
            if (mem_req && mem_we) found = 1;
        end
        chk("store_wait_seen", 64'(found), 64'd1);
        nrst = 1'b0;
        #1;
        chk("req_drop_on_rst", {63'd0, mem_req}, 64'd0);
        chk("pending_before_rst", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("no_write_on_rst", rd64(32'h08), 64'd0);
        mem.delete();
        wait_cfg = 0;
        put32(32'h00, enc_s(12'd16, 5'd1, 5'd0, 3'b011));
        put32(32'h04, 32'h0000_007F);
        p_rd(32'h00); p_st(32'h10, 64'd0); p_ret(32'h00, 4);
        p_rd(32'h04); p_halt(32'h04);
        repeat (2) @(posedge clk);
        release_reset();
        drain("drain_rst", 200);

        // Test D: taken backward beq into an illegal opcode
        enter_reset();
        mem.delete();
        put32(32'h00, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI));
        put32(32'h04, enc_b(13'd12, 5'd0, 5'd0));
        put32(32'h08, 32'h0000_007F);
        put32(32'h10, enc_b(13'h1FF8, 5'd1, 5'd1));
        p_rd(32'h00); p_ret(32'h00, 4);
        p_rd(32'h04); p_ret(32'h04, 7);
        p_rd(32'h10); p_ret(32'h10, 10);
        p_rd(32'h08); p_halt(32'h08);
        release_reset();
        drain("drain_beq", 200);
        repeat (20) @(posedge clk);
        #1;
        chk("halt_held", {63'd0, halt}, 64'd1);
        chk("halt_no_req", {63'd0, mem_req}, 64'd0);

        // Test E: XLEN=32 build accepts lw and rejects ld
        rdata32 = enc_i(12'd8, 5'd0, 3'b010, 5'd4, LD);
        @(posedge clk); #1;
        nrst32 = 1'b1;
        cnt = 0;
        repeat (30) begin @(negedge clk); #1; if (retire32) cnt++; end
        chk("x32_lw_retires", 64'(cnt), 64'd6);
        chk("x32_lw_no_halt", {63'd0, halt32}, 64'd0);
        nrst32 = 1'b0;
        rdata32 = enc_i(12'd8, 5'd0, 3'b011, 5'd4, LD);
        @(posedge clk); #1;
        nrst32 = 1'b1;
        cnt = 0;
        repeat (10) begin @(negedge clk); #1; if (retire32) cnt++; end
        chk("x32_ld_halt", {63'd0, halt32}, 64'd1);
        chk("x32_ld_no_req", {63'd0, req32}, 64'd0);
        chk("x32_ld_no_retire", 64'(cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
